veerwolf_uart_rx: RTL and testbench

//  Synthesizable UART receiver with byte FIFO. Consumes the serial line driven by the VeeRwolf

---
 rtl/veerwolf_uart_rx.sv | 166 ++++++++++++++++
 tb/tb_veerwolf_uart_rx.sv | 541 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/veerwolf_uart_rx.sv
// veerwolf_uart_rx: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Ports: clk_core/rst_core (sync, active high); i_uart_rx serial in (idle high);
//        o_rdata/o_rvalid/i_rready byte stream; o_frame_err/o_overrun one-cycle pulses;
//        o_frame_err_cnt/o_overrun_cnt saturating 8-bit error counts.
module veerwolf_uart_rx #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic       clk_core,
   input  logic       rst_core,
   input  logic       i_uart_rx,
   output logic [7:0] o_rdata,
   output logic       o_rvalid,
   input  logic       i_rready,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic [7:0] o_frame_err_cnt,
   output logic [7:0] o_overrun_cnt
);

   localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
   localparam int TW  = $clog2(CPB) + 1;
   localparam int AW  = $clog2(FIFO_DEPTH);

   localparam logic [TW-1:0] T_LAST = TW'(CPB - 1);
   localparam logic [TW-1:0] T_HALF = TW'(CPB / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   logic          rx_m;
   logic          rx_s;
   state_t        state;
   logic [TW-1:0] timer;
   logic [2:0]    idx;
   logic [7:0]    shreg;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;

   logic          tick;
   logic          empty;
   logic          full;
   logic          pop;
   logic          stop_ok;
   logic          stop_bad;
   logic          push;
   logic          drop;

   // Two-flop synchronizer, preset to the idle level.
   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= i_uart_rx;
         rx_s <= rx_m;
      end
   end

   assign tick     = (timer == T_LAST);
   assign stop_ok  = (state == S_STOP) && tick && rx_s;
   assign stop_bad = (state == S_STOP) && tick && !rx_s;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);
   assign pop   = !empty && i_rready;

   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push  = stop_ok && (!full || pop);
   assign drop  = stop_ok && full && !pop;

   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         state <= S_IDLE;
         timer <= '0;
         idx   <= '0;
         shreg <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               timer <= '0;
               if (!rx_s) state <= S_START;
            end
            S_START: begin
               if (timer == T_HALF) begin
                  timer <= '0;
                  idx   <= '0;
                  // Line back high at mid start bit: treat as a glitch.
                  state <= rx_s ? S_IDLE : S_DATA;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_DATA: begin
               if (tick) begin
                  timer      <= '0;
                  shreg[idx] <= rx_s;
                  idx        <= idx + 1'b1;
                  if (idx == 3'd7) state <= S_STOP;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_STOP: begin
               if (tick) begin
                  timer <= '0;
                  state <= rx_s ? S_IDLE : S_BREAK;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_BREAK: begin
               // Stay here while the line is held low so a break
               // produces exactly one frame error.
               timer <= '0;
               if (rx_s) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         o_frame_err     <= 1'b0;
         o_overrun       <= 1'b0;
         o_frame_err_cnt <= '0;
         o_overrun_cnt   <= '0;
      end else begin
         o_frame_err <= stop_bad;
         o_overrun   <= drop;
         if (stop_bad && o_frame_err_cnt != 8'hFF)
            o_frame_err_cnt <= o_frame_err_cnt + 1'b1;
         if (drop && o_overrun_cnt != 8'hFF)
            o_overrun_cnt <= o_overrun_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk_core) begin
      if (push) mem[wptr[AW-1:0]] <= shreg;
   end

   // Storage is not reset; mask the head so o_rdata reads 0 when empty.
   assign o_rvalid = !empty;
   assign o_rdata  = empty ? 8'h00 : mem[rptr[AW-1:0]];

endmodule

// File: tb/tb_veerwolf_uart_rx.sv
// tb_veerwolf_uart_rx: randomized self-checking bench for veerwolf_uart_rx.
// 16 clocks per bit, 4-entry FIFO; reference model tracks queued bytes and error counts.
module tb_veerwolf_uart_rx;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       rx_line = 1'b1;
   logic       rready  = 1'b0;
   logic [7:0] rdata;
   logic       rvalid;
   logic       frame_err;
   logic       overrun;
   logic [7:0] fe_cnt;
   logic [7:0] ov_cnt;

   veerwolf_uart_rx #(
      .CLK_FREQ_HZ (1_600_000),
      .BAUD_RATE   (100_000),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk_core        (clk),
      .rst_core        (rst),
      .i_uart_rx       (rx_line),
      .o_rdata         (rdata),
      .o_rvalid        (rvalid),
      .i_rready        (rready),
      .o_frame_err     (frame_err),
      .o_overrun       (overrun),
      .o_frame_err_cnt (fe_cnt),
      .o_overrun_cnt   (ov_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0] got[$];
   logic [7:0] exp_q[$];
   logic [7:0] mq[$];
   int fe_seen = 0;
   int ov_seen = 0;
   int exp_fe  = 0;
   int exp_ov  = 0;

   // Passive monitor: records accepted bytes and pulse cycles.
   always @(negedge clk) begin
      if (!rst) begin
         if (rvalid && rready) got.push_back(rdata);
         if (frame_err) fe_seen++;
         if (overrun) ov_seen++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [7:0] sat(input int n);
      return (n > 255) ? 8'hFF : 8'(n);
   endfunction

   // Reference: a frame with a good stop bit is queued if there is room,
   // otherwise counted as an overrun; a bad stop bit is a frame error.
   task automatic model_rx(input logic [7:0] b, input logic stop);
      if (!stop) exp_fe++;
      else if (mq.size() < DEPTH) begin
         mq.push_back(b);
         exp_q.push_back(b);
      end else exp_ov++;
   endtask

   task automatic hold(input logic v, input int n);
      rx_line = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold(b[i], CPB);
      hold(stop, CPB);
   endtask

   task automatic do_reset;
      @(posedge clk);
      #1;
      rst = 1'b1;
      rx_line = 1'b1;
      rready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      got.delete();
      exp_q.delete();
      mq.delete();
      fe_seen = 0;
      ov_seen = 0;
      exp_fe = 0;
      exp_ov = 0;
   endtask

   task automatic drain;
      rready = 1'b1;
      repeat (2 * DEPTH + 4) @(posedge clk);
      #1;
      rready = 1'b0;
      mq.delete();
   endtask

   task automatic test_reset;
      do_reset();
      @(negedge clk);
      total++;
      if (rvalid !== 1'b0) begin
         bad++;
         $display("FAIL reset_rvalid got=%b exp=0", rvalid);
      end
      total++;
      if (rdata !== 8'h00) begin
         bad++;
         $display("FAIL reset_rdata got=%h exp=00", rdata);
      end
      total++;
      if (fe_cnt !== 8'h00 || ov_cnt !== 8'h00) begin
         bad++;
         $display("FAIL reset_cnt got=%h/%h exp=00/00", fe_cnt, ov_cnt);
      end
      total++;
      if (frame_err !== 1'b0 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL reset_pulse got=%b/%b exp=0/0", frame_err, overrun);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_single;
      got.delete();
      exp_q.delete();
      rready = 1'b1;
      hold(1'b1, 8);
      model_rx(8'hA5, 1'b1);
      send_frame(8'hA5, 1'b1);
      hold(1'b1, 8);
      mq.delete();
      total++;
      if (got.size() != 1 || got[0] !== 8'hA5) begin
         bad++;
         $display("FAIL single n=%0d got=%h exp=a5", got.size(),
                  got.size() > 0 ? got[0] : 8'hxx);
      end
      total++;
      if (fe_seen != 0 || ov_seen != 0) begin
         bad++;
         $display("FAIL single_pulses got=%0d/%0d exp=0/0", fe_seen, ov_seen);
      end
      total++;
      if (fe_cnt !== 8'h00 || ov_cnt !== 8'h00) begin
         bad++;
         $display("FAIL single_cnt got=%h/%h exp=00/00", fe_cnt, ov_cnt);
      end
      rready = 1'b0;
   endtask

   task automatic test_backpressure;
      logic [7:0] pat [4];
      pat = '{8'h00, 8'hFF, 8'h3C, 8'h81};
      got.delete();
      exp_q.delete();
      rready = 1'b0;
      foreach (pat[i]) begin
         model_rx(pat[i], 1'b1);
         send_frame(pat[i], 1'b1);
         hold(1'b1, 4);
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         total++;
         if (rvalid !== 1'b1 || rdata !== exp_q[0]) begin
            bad++;
            $display("FAIL bp_hold c=%0d got=%b/%h exp=1/%h",
                     c, rvalid, rdata, exp_q[0]);
         end
      end
      @(posedge clk);
      #1;
      drain();
      total++;
      if (got.size() != exp_q.size()) begin
         bad++;
         $display("FAIL bp_count got=%0d exp=%0d", got.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         total++;
         if (i >= got.size() || got[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL bp_byte%0d got=%h exp=%h", i,
                     i < got.size() ? got[i] : 8'hxx, exp_q[i]);
         end
      end
      total++;
      if (rvalid !== 1'b0) begin
         bad++;
         $display("FAIL bp_empty got=%b exp=0", rvalid);
      end
   endtask

   task automatic test_overrun;
      logic [7:0] b;
      got.delete();
      exp_q.delete();
      rready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         b = 8'($urandom);
         model_rx(b, 1'b1);
         send_frame(b, 1'b1);
         hold(1'b1, 4);
      end
      model_rx(8'h55, 1'b1);
      send_frame(8'h55, 1'b1);
      hold(1'b1, 4);
      total++;
      if (ov_seen != exp_ov) begin
         bad++;
         $display("FAIL ovr_pulse got=%0d exp=%0d", ov_seen, exp_ov);
      end
      total++;
      if (ov_cnt !== sat(exp_ov)) begin
         bad++;
         $display("FAIL ovr_cnt got=%h exp=%h", ov_cnt, sat(exp_ov));
      end
      drain();
      total++;
      if (got.size() != exp_q.size()) begin
         bad++;
         $display("FAIL ovr_count got=%0d exp=%0d", got.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         total++;
         if (i >= got.size() || got[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL ovr_byte%0d got=%h exp=%h", i,
                     i < got.size() ? got[i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   task automatic test_frame_error;
      got.delete();
      exp_q.delete();
      rready = 1'b1;
      model_rx(8'h12, 1'b0);
      send_frame(8'h12, 1'b0);
      hold(1'b0, 40 * CPB);
      hold(1'b1, 2 * CPB);
      total++;
      if (fe_seen != exp_fe) begin
         bad++;
         $display("FAIL fe_pulse got=%0d exp=%0d", fe_seen, exp_fe);
      end
      total++;
      if (fe_cnt !== sat(exp_fe)) begin
         bad++;
         $display("FAIL fe_cnt got=%h exp=%h", fe_cnt, sat(exp_fe));
      end
      total++;
      if (got.size() != 0 || rvalid !== 1'b0) begin
         bad++;
         $display("FAIL fe_nobyte got=%0d/%b exp=0/0", got.size(), rvalid);
      end
      model_rx(8'h34, 1'b1);
      send_frame(8'h34, 1'b1);
      hold(1'b1, 8);
      mq.delete();
      total++;
      if (got.size() != 1 || got[0] !== 8'h34) begin
         bad++;
         $display("FAIL fe_after n=%0d got=%h exp=34", got.size(),
                  got.size() > 0 ? got[0] : 8'hxx);
      end
      total++;
      if (fe_seen != exp_fe) begin
         bad++;
         $display("FAIL fe_repeat got=%0d exp=%0d", fe_seen, exp_fe);
      end
      rready = 1'b0;
   endtask

   task automatic test_glitch;
      got.delete();
      exp_q.delete();
      rready = 1'b1;
      hold(1'b0, 4);
      hold(1'b1, 40);
      total++;
      if (got.size() != 0 || fe_seen != exp_fe || ov_seen != exp_ov) begin
         bad++;
         $display("FAIL glitch got=%0d/%0d/%0d exp=0/%0d/%0d",
                  got.size(), fe_seen, ov_seen, exp_fe, exp_ov);
      end
      model_rx(8'h5A, 1'b1);
      send_frame(8'h5A, 1'b1);
      hold(1'b1, 8);
      mq.delete();
      total++;
      if (got.size() != 1 || got[0] !== 8'h5A) begin
         bad++;
         $display("FAIL glitch_after n=%0d got=%h exp=5a", got.size(),
                  got.size() > 0 ? got[0] : 8'hxx);
      end
      rready = 1'b0;
   endtask

   task automatic test_reset_midframe;
      logic [7:0] b;
      logic [7:0] p;
      got.delete();
      exp_q.delete();
      rready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         b = 8'($urandom);
         model_rx(b, 1'b1);
         send_frame(b, 1'b1);
         hold(1'b1, 4);
      end
      @(negedge clk);
      total++;
      if (rvalid !== 1'b1) begin
         bad++;
         $display("FAIL rst_pre got=%b exp=1", rvalid);
      end
      @(posedge clk);
      #1;
      p = 8'h77;
      hold(1'b0, CPB);
      for (int i = 0; i < 3; i++) hold(p[i], CPB);
      hold(p[3], CPB / 2);
      rst = 1'b1;
      rx_line = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      got.delete();
      exp_q.delete();
      mq.delete();
      fe_seen = 0;
      ov_seen = 0;
      exp_fe = 0;
      exp_ov = 0;
      @(negedge clk);
      total++;
      if (rvalid !== 1'b0 || rdata !== 8'h00) begin
         bad++;
         $display("FAIL rst_mid got=%b/%h exp=0/00", rvalid, rdata);
      end
      total++;
      if (fe_cnt !== 8'h00 || ov_cnt !== 8'h00) begin
         bad++;
         $display("FAIL rst_mid_cnt got=%h/%h exp=00/00", fe_cnt, ov_cnt);
      end
      @(posedge clk);
      #1;
      hold(1'b1, 8);
      rready = 1'b1;
      model_rx(8'h99, 1'b1);
      send_frame(8'h99, 1'b1);
      hold(1'b1, 8);
      mq.delete();
      total++;
      if (got.size() != 1 || got[0] !== 8'h99 || fe_seen != 0) begin
         bad++;
         $display("FAIL rst_after n=%0d got=%h fe=%0d exp=99 fe=0",
                  got.size(), got.size() > 0 ? got[0] : 8'hxx, fe_seen);
      end
      rready = 1'b0;
   endtask

   task automatic test_random;
      logic [7:0] b;
      logic       st;
      logic       done;
      got.delete();
      exp_q.delete();
      done = 1'b0;
      fork
         begin
            for (int k = 0; k < 10; k++) begin
               b = 8'($urandom);
               st = ($urandom_range(0, 3) != 0);
               model_rx(b, st);
               send_frame(b, st);
               hold(1'b1, 8);
               mq.delete();
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               rready = 1'($urandom_range(0, 1));
            end
         end
      join
      drain();
      total++;
      if (got.size() != exp_q.size()) begin
         bad++;
         $display("FAIL rnd_count got=%0d exp=%0d", got.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         total++;
         if (i >= got.size() || got[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL rnd_byte%0d got=%h exp=%h", i,
                     i < got.size() ? got[i] : 8'hxx, exp_q[i]);
         end
      end
      total++;
      if (fe_seen != exp_fe || fe_cnt !== sat(exp_fe)) begin
         bad++;
         $display("FAIL rnd_fe got=%0d/%h exp=%0d", fe_seen, fe_cnt, exp_fe);
      end
   endtask

   task automatic test_saturation;
      logic [7:0] b;
      do_reset();
      for (int k = 0; k < 304; k++) begin
         b = 8'($urandom);
         model_rx(b, 1'b1);
         send_frame(b, 1'b1);
      end
      hold(1'b1, 8);
      total++;
      if (ov_seen != exp_ov) begin
         bad++;
         $display("FAIL sat_pulses got=%0d exp=%0d", ov_seen, exp_ov);
      end
      total++;
      if (ov_cnt !== sat(exp_ov)) begin
         bad++;
         $display("FAIL sat_cnt got=%h exp=%h", ov_cnt, sat(exp_ov));
      end
      total++;
      if (fe_cnt !== 8'h00) begin
         bad++;
         $display("FAIL sat_fe got=%h exp=00", fe_cnt);
      end
      drain();
      total++;
      if (got.size() != exp_q.size()) begin
         bad++;
         $display("FAIL sat_count got=%0d exp=%0d", got.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         total++;
         if (i >= got.size() || got[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL sat_byte%0d got=%h exp=%h", i,
                     i < got.size() ? got[i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   task automatic test_full_push_pop;
      logic [7:0] b;
      int         ov0;
      do_reset();
      for (int k = 0; k < DEPTH; k++) begin
         b = 8'($urandom);
         model_rx(b, 1'b1);
         send_frame(b, 1'b1);
         hold(1'b1, 4);
      end
      ov0 = ov_seen;
      b = 8'($urandom);
      // Stop bit is sampled 155 clocks after the edge preceding the
      // start bit (152 for 9.5 bits, 2 sync, 1 idle detect).
      void'(mq.pop_front());
      model_rx(b, 1'b1);
      fork
         send_frame(b, 1'b1);
         begin
            repeat (154) @(posedge clk);
            #1;
            rready = 1'b1;
            @(posedge clk);
            #1;
            rready = 1'b0;
         end
      join
      hold(1'b1, 4);
      total++;
      if (ov_seen != ov0 || ov_cnt !== 8'h00) begin
         bad++;
         $display("FAIL fpp_overrun got=%0d/%h exp=%0d/00", ov_seen, ov_cnt, ov0);
      end
      total++;
      if (got.size() != 1 || rvalid !== 1'b1) begin
         bad++;
         $display("FAIL fpp_pop got=%0d/%b exp=1/1", got.size(), rvalid);
      end
      drain();
      total++;
      if (got.size() != exp_q.size()) begin
         bad++;
         $display("FAIL fpp_count got=%0d exp=%0d", got.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         total++;
         if (i >= got.size() || got[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL fpp_byte%0d got=%h exp=%h", i,
                     i < got.size() ? got[i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_overrun();
      test_frame_error();
      test_glitch();
      test_reset_midframe();
      test_random();
      test_saturation();
      test_full_push_pop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
